// File: rtl/soc_system_ram_streamer_pkg.sv
// Shared defaults and FSM state type for the RAM-to-stream reader.
// No logic; sizing only.
package soc_system_ram_streamer_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/soc_system_ram_streamer_skid.sv
// Two-entry FIFO holding RAM read data; head is registered, 0-cycle read of head.
// Push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module soc_system_ram_streamer_skid
  import soc_system_ram_streamer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        cnt_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/soc_system_ram_streamer.sv
// Streams length words from on-chip RAM to an Avalon-ST source; first beat 2 cycles after start, then 1/cycle.
// Reads throttled so buffered + in-flight never exceeds 2; SOC_SYSTEM_RAM_STREAMER_PARITY_EN adds src_parity.
module soc_system_ram_streamer
  import soc_system_ram_streamer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [LEN_W-1:0]    length,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_chipselect,
  output logic                ram_clken,
  output logic                ram_write,
  output logic [DATA_W/8-1:0] ram_byteenable,
  input  logic [DATA_W-1:0]   ram_readdata,
  output logic                src_valid,
  input  logic                src_ready,
  output logic [DATA_W-1:0]   src_data,
  output logic                src_sop,
`ifdef SOC_SYSTEM_RAM_STREAMER_PARITY_EN
  output logic                src_parity,
`endif
  output logic                src_eop
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rd_left_q, rd_left_d;
  logic [LEN_W-1:0]  beat_left_q, beat_left_d;
  logic              first_q, first_d;
  logic              done_q, done_d;
  logic              inflight_q;
  logic              rd_en;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        occ;
  logic [2:0]        pending;

  assign src_valid = ~fifo_empty;
  assign pop       = src_valid & src_ready;
  assign occ       = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  // Occupancy as it will be after this cycle's pop, so a steady stream can issue every cycle.
  assign pending   = {1'b0, occ} - {2'b0, pop} + {2'b0, inflight_q};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_left_d   = rd_left_q;
    beat_left_d = beat_left_q;
    first_d     = first_q;
    done_d      = 1'b0;
    rd_en       = 1'b0;
    ram_address = addr_q;
    if (pop) begin
      beat_left_d = beat_left_q - LEN_W'(1);
      first_d     = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            // First read goes out in the start cycle itself to reach the 2-cycle latency.
            rd_en       = 1'b1;
            ram_address = start_addr;
            addr_d      = start_addr + ADDR_W'(1);
            rd_left_d   = length - LEN_W'(1);
            beat_left_d = length;
            first_d     = 1'b1;
            state_d     = (length == LEN_W'(1)) ? ST_DRAIN : ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (pending < 3'd2) begin
          rd_en     = 1'b1;
          addr_d    = addr_q + ADDR_W'(1);
          rd_left_d = rd_left_q - LEN_W'(1);
          if (rd_left_q == LEN_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && (beat_left_q == LEN_W'(1))) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rd_left_q   <= '0;
      beat_left_q <= '0;
      first_q     <= 1'b0;
      done_q      <= 1'b0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_left_q   <= rd_left_d;
      beat_left_q <= beat_left_d;
      first_q     <= first_d;
      done_q      <= done_d;
      inflight_q  <= rd_en;
    end
  end

  soc_system_ram_streamer_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (inflight_q),
    .push_data_i (ram_readdata),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (src_data)
  );

  assign busy           = (state_q != ST_IDLE) | done_q;
  assign done           = done_q;
  assign ram_chipselect = rd_en;
  assign ram_clken      = rd_en;
  assign ram_write      = 1'b0;
  assign ram_byteenable = '1;
  assign src_sop        = src_valid & first_q;
  assign src_eop        = src_valid & (beat_left_q == LEN_W'(1));

`ifdef SOC_SYSTEM_RAM_STREAMER_PARITY_EN
  assign src_parity = ^src_data;
`endif

endmodule

// File: tb/tb_soc_system_ram_streamer.sv
// Bench for soc_system_ram_streamer: table of transfers, scoreboard of addresses and beats, reset abort.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_soc_system_ram_streamer;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 15;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                start;
  logic [ADDR_W-1:0]   start_addr;
  logic [LEN_W-1:0]    length;
  logic                busy, done;
  logic [ADDR_W-1:0]   ram_address;
  logic                ram_chipselect, ram_clken, ram_write;
  logic [DATA_W/8-1:0] ram_byteenable;
  logic [DATA_W-1:0]   ram_readdata;
  logic                src_valid, src_ready, src_sop, src_eop;
  logic [DATA_W-1:0]   src_data;
`ifdef SOC_SYSTEM_RAM_STREAMER_PARITY_EN
  logic                src_parity;
`endif

  always #5 clk = ~clk;

  soc_system_ram_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .start_addr     (start_addr),
    .length         (length),
    .busy           (busy),
    .done           (done),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_clken      (ram_clken),
    .ram_write      (ram_write),
    .ram_byteenable (ram_byteenable),
    .ram_readdata   (ram_readdata),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .src_data       (src_data),
    .src_sop        (src_sop),
`ifdef SOC_SYSTEM_RAM_STREAMER_PARITY_EN
    .src_parity     (src_parity),
`endif
    .src_eop        (src_eop)
  );

  // RAM model: word n holds n, one-cycle read latency, output holds without clken.
  always @(posedge clk) begin
    if (ram_clken) ram_readdata <= DATA_W'(ram_address);
  end

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    bit                toggle;
    int                exp_lat;   // start to first src_valid, or start to done when len==0
    int                exp_done;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } beat_t;

  vec_t              tbl[5];
  beat_t             exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  beat_t             held;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  bit toggle_mode = 1'b0;
  bit stall_q = 1'b0;
  int beats_rx = 0, valid_cnt = 0, clken_cnt = 0, done_cnt = 0;
  int done_cyc = -1, first_vld_cyc = -1, last_hs_cyc = -1;
  int issued = 0, popped = 0, max_out = 0;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sample();
    beat_t e;
    if (issued - popped > max_out) max_out = issued - popped;
    if (ram_clken) begin
      clken_cnt++;
      issued++;
      if (addr_q.size() == 0) begin
        check("unexpected_read", 1'b0, ram_address, 0);
      end else begin
        logic [ADDR_W-1:0] a;
        a = addr_q.pop_front();
        check("read_addr", ram_address == a && ram_chipselect, ram_address, a);
      end
    end
    if (stall_q) begin
      check("hold", src_valid && src_data == held.data && src_sop == held.sop && src_eop == held.eop,
            {src_valid, src_data, src_sop, src_eop}, {1'b1, held.data, held.sop, held.eop});
    end
    if (src_valid) begin
      valid_cnt++;
      if (first_vld_cyc < 0) first_vld_cyc = cyc;
    end
    if (src_valid && src_ready) begin
      beats_rx++;
      popped++;
      last_hs_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1'b0, src_data, 0);
      end else begin
        e = exp_q.pop_front();
        check("beat", src_data == e.data && src_sop == e.sop && src_eop == e.eop,
              {src_data, src_sop, src_eop}, {e.data, e.sop, e.eop});
`ifdef SOC_SYSTEM_RAM_STREAMER_PARITY_EN
        check("parity", src_parity == ^e.data, src_parity, ^e.data);
`endif
      end
    end
    stall_q = src_valid && !src_ready;
    held = '{data: src_data, sop: src_sop, eop: src_eop};
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
    src_ready = toggle_mode ? ~src_ready : 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  busy == 1'b0, busy, 0);
    check({tag, "_done"},  done == 1'b0, done, 0);
    check({tag, "_valid"}, src_valid == 1'b0, src_valid, 0);
    check({tag, "_cs"},    ram_chipselect == 1'b0, ram_chipselect, 0);
    check({tag, "_clken"}, ram_clken == 1'b0, ram_clken, 0);
    check({tag, "_addr"},  ram_address == '0, ram_address, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int b_beats, b_done, b_valid, b_clk, start_cyc, k;
    logic [ADDR_W-1:0] a;
    b_beats = beats_rx; b_done = done_cnt; b_valid = valid_cnt; b_clk = clken_cnt;
    toggle_mode   = v.toggle;
    first_vld_cyc = -1;
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.addr + ADDR_W'(i);
      addr_q.push_back(a);
      exp_q.push_back('{data: DATA_W'(a), sop: (i == 0), eop: (i == int'(v.len) - 1)});
    end
    start = 1'b1; start_addr = v.addr; length = v.len; start_cyc = cyc;
    tick();
    start = 1'b0;
    if (v.len == '0) begin
      check("len0_busy", busy == 1'b1, busy, 1);
      check("len0_done", done == 1'b1, done, 1);
      tick();
      check("len0_busy_after", busy == 1'b0, busy, 0);
    end else begin
      k = 0;
      while (done_cnt == b_done && k < 300) begin
        tick();
        k++;
      end
      check("done_timeout", done_cnt != b_done, k, 300);
    end
    repeat (3) tick();
    toggle_mode = 1'b0;
    check("done_count", done_cnt - b_done == v.exp_done, done_cnt - b_done, v.exp_done);
    check("beat_count", beats_rx - b_beats == int'(v.len), beats_rx - b_beats, v.len);
    check("read_count", clken_cnt - b_clk == int'(v.len), clken_cnt - b_clk, v.len);
    check("scoreboard_empty", exp_q.size() == 0 && addr_q.size() == 0, exp_q.size() + addr_q.size(), 0);
    if (v.len == '0) begin
      check("len0_done_lat", done_cyc - start_cyc == v.exp_lat, done_cyc - start_cyc, v.exp_lat);
      check("len0_no_valid", valid_cnt == b_valid, valid_cnt - b_valid, 0);
    end else begin
      check("first_latency", first_vld_cyc - start_cyc == v.exp_lat, first_vld_cyc - start_cyc, v.exp_lat);
      if (!v.toggle)
        check("throughput", last_hs_cyc - first_vld_cyc == int'(v.len) - 1,
              last_hs_cyc - first_vld_cyc, int'(v.len) - 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int b_done, b_valid, b_clk;
    tbl[0] = '{addr: 14'h0010, len: 15'd4, toggle: 1'b0, exp_lat: 2, exp_done: 1};
    tbl[1] = '{addr: 14'h3FFE, len: 15'd4, toggle: 1'b0, exp_lat: 2, exp_done: 1};
    tbl[2] = '{addr: 14'h0100, len: 15'd8, toggle: 1'b1, exp_lat: 2, exp_done: 1};
    tbl[3] = '{addr: 14'h0020, len: 15'd1, toggle: 1'b0, exp_lat: 2, exp_done: 1};
    tbl[4] = '{addr: 14'h0000, len: 15'd0, toggle: 1'b0, exp_lat: 1, exp_done: 1};

    reset_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; src_ready = 1'b1;
    #1;
    check_reset_outputs("reset");
    check("ram_write", ram_write == 1'b0, ram_write, 0);
    check("byteenable", ram_byteenable == 4'hF, ram_byteenable, 4'hF);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 5; i++) run_vec(tbl[i]);

`ifdef SOC_SYSTEM_RAM_STREAMER_PARITY_EN
    run_vec('{addr: 14'h0007, len: 15'd1, toggle: 1'b0, exp_lat: 2, exp_done: 1});
    run_vec('{addr: 14'h0003, len: 15'd1, toggle: 1'b0, exp_lat: 2, exp_done: 1});
`endif

    // Second start mid-transfer must be ignored; reset during RUN aborts without done.
    b_done = done_cnt;
    for (int i = 0; i < 8; i++) begin
      addr_q.push_back(ADDR_W'(14'h0040 + i));
      exp_q.push_back('{data: DATA_W'(14'h0040 + i), sop: (i == 0), eop: (i == 7)});
    end
    start = 1'b1; start_addr = 14'h0040; length = 15'd8;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; start_addr = 14'h0200; length = 15'd3;
    check("busy_mid", busy == 1'b1, busy, 1);
    tick();
    start = 1'b0;
    tick();
    check("busy_before_abort", busy == 1'b1, busy, 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) tick();
    exp_q.delete();
    addr_q.delete();
    issued = 0; popped = 0; stall_q = 1'b0;
    b_valid = valid_cnt; b_clk = clken_cnt;
    reset_n = 1'b1;
    repeat (5) tick();
    check("abort_no_done", done_cnt == b_done, done_cnt - b_done, 0);
    check("abort_no_valid", valid_cnt == b_valid, valid_cnt - b_valid, 0);
    check("abort_no_read", clken_cnt == b_clk, clken_cnt - b_clk, 0);
    check("abort_idle", busy == 1'b0, busy, 0);

    run_vec(tbl[0]);

    check("max_outstanding", max_out <= 2, max_out, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_system_ram_streamer.md
SOC_SYSTEM_RAM_STREAMER -- requirements
Module: soc_system_ram_streamer

Interface
REQ-001 Parameter ADDR_W, default 14, sets the word-address width of the on-chip RAM port.
REQ-002 Parameter DATA_W, default 32, sets the RAM and stream data width.
REQ-003 Parameter LEN_W, default 15, sets the width of the transfer length in words (max 16384).
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous active-low reset.
REQ-006 Port start, input, 1: one-cycle request to begin a transfer; sampled only in IDLE.
REQ-007 Port start_addr, input, ADDR_W: first word address, captured on accepted start.
REQ-008 Port length, input, LEN_W: number of words to stream, captured on accepted start.
REQ-009 Port busy, output, 1: high from accepted start until the cycle done is asserted.
REQ-010 Port done, output, 1: one-cycle pulse when the last beat is accepted downstream.
REQ-011 Port ram_address, output, ADDR_W: word address to the RAM slave.
REQ-012 Port ram_chipselect / ram_clken, outputs, 1 each: read strobe and clock enable to the RAM.
REQ-013 Port ram_write, output, 1: tied 0; ram_byteenable, output, DATA_W/8: tied all-ones.
REQ-014 Port ram_readdata, input, DATA_W: RAM read data, valid one cycle after a clken-qualified address.
REQ-015 Ports src_valid (output, 1), src_ready (input, 1), src_data (output, DATA_W), src_sop (output, 1), src_eop (output, 1): Avalon-ST source.

Function
REQ-016 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start with length>0; RUN->DRAIN when the final read is issued; DRAIN->IDLE when the final beat transfers (src_valid&src_ready).
REQ-017 start with length==0 SHALL produce done one cycle later, no RAM reads, no beats, busy high for that one cycle only.
REQ-018 start while busy SHALL be ignored with no effect on the running transfer.
REQ-019 A read is issued (ram_clken=ram_chipselect=1) only when buffer occupancy plus in-flight reads is less than 2; read latency is exactly 1 cycle.
REQ-020 Read addresses increment by 1 per issued read and wrap from 2^ADDR_W-1 to 0.
REQ-021 Returned data enters a 2-entry FIFO in issue order; src_data is FIFO head, src_valid = FIFO non-empty.
REQ-022 With src_ready held high, throughput SHALL be one beat per cycle after a 2-cycle initial latency (start to first src_valid).
REQ-023 src_sop SHALL be high on the first beat only, src_eop on the last beat only; both on a 1-word transfer.
REQ-024 src_data, src_sop, src_eop SHALL hold stable while src_valid=1 and src_ready=0.
REQ-025 ram_clken SHALL be 0 whenever no read is issued, so RAM output holds.

Reset
REQ-026 On reset_n low, asynchronously: state IDLE, FIFO empty, counters 0, busy=0, done=0, src_valid=0, ram_chipselect=0, ram_clken=0, ram_address=0.
REQ-027 Reset asserted mid-transfer SHALL abort it with no done pulse; in-flight read data is discarded.

Configuration
REQ-028 Macro SOC_SYSTEM_RAM_STREAMER_PARITY_EN defined: output src_parity (1 bit) = even parity (XOR) of src_data, following the same hold rules as src_data.
REQ-029 Macro undefined: no src_parity port and no parity logic.

Structure
REQ-030 Package soc_system_ram_streamer_pkg holds ADDR_W/DATA_W/LEN_W defaults and the state enum type.
REQ-031 Sub-module soc_system_ram_streamer_skid implements the 2-entry FIFO (push, pop, full, empty, head data).

Verification
REQ-032 start_addr=0x0010, length=4, src_ready=1, RAM word n holds n -> beats 0x10,0x11,0x12,0x13 on consecutive cycles, sop on first, eop on last, one done.
REQ-033 start_addr=0x3FFE, length=4 -> reads of 0x3FFE,0x3FFF,0x0000,0x0001 in that order.
REQ-034 length=8, src_ready toggling 1/0 each cycle -> all 8 beats in order, data stable during stalls, never more than 2 reads outstanding+buffered.
REQ-035 length=0 -> done exactly one cycle after start, src_valid never asserted, ram_clken never asserted.
REQ-036 Second start mid-transfer, then reset_n low during RUN -> second start ignored; after reset all outputs at reset values, no done.
REQ-037 PARITY_EN build, data 0x00000007 -> src_parity=1; data 0x00000003 -> src_parity=0.
